// File: rtl/ch_rd_burst_gen.sv
// Per-channel AXI4 read-address generator: splits a channel region into AR bursts that never cross 4 KB.
// Latency: arvalid one cycle after start; done one cycle after the final RLAST. Backpressure: AR held stable on !arready; in-flight bursts capped at MAX_OUTSTANDING.
// Optional statistics counters are built only when CH_RD_STATS_EN is defined.
module ch_rd_burst_gen #(
    parameter int ADDR_W          = 64,
    parameter int LEN_W           = 32,
    parameter int BYTES_PER_BEAT  = 64,
    parameter int BURST_BEATS     = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic              aclk,
    input  logic              areset_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_ch_base,
    input  logic [LEN_W-1:0]  i_num_bytes,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic              i_rlast_hs,
    output logic [31:0]       o_stat_bursts,
    output logic [31:0]       o_stat_stalls
);

    localparam int BSHIFT     = $clog2(BYTES_PER_BEAT);
    localparam int PAGE_BEATS = 4096 / BYTES_PER_BEAT;
    localparam int CW         = LEN_W + 1;
    localparam int OW         = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  beats_left, beats_left_nxt;
    logic [OW-1:0]     outstanding, outstanding_nxt;
    logic [ADDR_W-1:0] araddr_nxt;
    logic [7:0]        arlen_nxt;
    logic              arvalid_nxt;
    logic              busy_nxt;
    logic              done_nxt;

    // Burst size limited by remaining beats, max burst length and distance to the next 4 KB page.
    function automatic logic [8:0] calc_n(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] left);
        logic [CW-1:0] m;
        logic [CW-1:0] pg;
        pg = CW'(PAGE_BEATS) - CW'(a[11:BSHIFT]);
        m  = CW'(BURST_BEATS);
        if (pg < m) begin
            m = pg;
        end
        if (CW'(left) < m) begin
            m = CW'(left);
        end
        return m[8:0];
    endfunction

    logic              hs;
    logic              rlast_dec;
    logic [CW-1:0]     bytes_rnd;
    logic [LEN_W-1:0]  start_beats;
    logic [ADDR_W-1:0] start_addr;
    logic [8:0]        start_n;
    logic [8:0]        cur_n;
    logic [ADDR_W-1:0] hs_addr;
    logic [LEN_W-1:0]  hs_left;
    logic [8:0]        hs_n;

    assign hs          = m_axi_arvalid & m_axi_arready;
    assign rlast_dec   = i_rlast_hs && (outstanding != '0);
    assign bytes_rnd   = {1'b0, i_num_bytes} + CW'(BYTES_PER_BEAT - 1);
    assign start_beats = LEN_W'(bytes_rnd >> BSHIFT);
    assign start_addr  = i_ch_base & ~ADDR_W'(BYTES_PER_BEAT - 1);
    assign start_n     = calc_n(start_addr, start_beats);

    // Next burst is derived from the one currently on the bus so a handshake can chain straight into it.
    assign cur_n   = {1'b0, m_axi_arlen} + 9'd1;
    assign hs_addr = m_axi_araddr + (ADDR_W'(cur_n) << BSHIFT);
    assign hs_left = beats_left - LEN_W'(cur_n);
    assign hs_n    = calc_n(hs_addr, hs_left);

    always_comb begin
        outstanding_nxt = outstanding;
        if (hs && !rlast_dec) begin
            outstanding_nxt = outstanding + 1'b1;
        end else if (!hs && rlast_dec) begin
            outstanding_nxt = outstanding - 1'b1;
        end
    end

    always_comb begin
        state_nxt      = state;
        araddr_nxt     = m_axi_araddr;
        arlen_nxt      = m_axi_arlen;
        arvalid_nxt    = m_axi_arvalid;
        beats_left_nxt = beats_left;
        busy_nxt       = o_busy;
        done_nxt       = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    if (start_beats == '0) begin
                        done_nxt = 1'b1;
                        busy_nxt = 1'b0;
                    end else begin
                        araddr_nxt     = start_addr;
                        arlen_nxt      = 8'(start_n - 9'd1);
                        beats_left_nxt = start_beats;
                        arvalid_nxt    = 1'b1;
                        busy_nxt       = 1'b1;
                        state_nxt      = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (hs) begin
                    araddr_nxt     = hs_addr;
                    beats_left_nxt = hs_left;
                    if (hs_left == '0) begin
                        arvalid_nxt = 1'b0;
                        state_nxt   = DRAIN;
                    end else begin
                        arlen_nxt   = 8'(hs_n - 9'd1);
                        arvalid_nxt = (outstanding_nxt < OW'(MAX_OUTSTANDING));
                    end
                end else if (!m_axi_arvalid) begin
                    arvalid_nxt = (outstanding_nxt < OW'(MAX_OUTSTANDING));
                end
            end
            DRAIN: begin
                if (outstanding_nxt == '0) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt   = IDLE;
                arvalid_nxt = 1'b0;
                busy_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state         <= IDLE;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            m_axi_arvalid <= 1'b0;
            beats_left    <= '0;
            outstanding   <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            state         <= state_nxt;
            m_axi_araddr  <= araddr_nxt;
            m_axi_arlen   <= arlen_nxt;
            m_axi_arvalid <= arvalid_nxt;
            beats_left    <= beats_left_nxt;
            outstanding   <= outstanding_nxt;
            o_busy        <= busy_nxt;
            o_done        <= done_nxt;
        end
    end

`ifdef CH_RD_STATS_EN
    logic [31:0] stat_bursts;
    logic [31:0] stat_stalls;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            stat_bursts <= '0;
            stat_stalls <= '0;
        end else if (state == IDLE && i_start) begin
            stat_bursts <= '0;
            stat_stalls <= '0;
        end else begin
            if (hs && stat_bursts != '1) begin
                stat_bursts <= stat_bursts + 32'd1;
            end
            if (m_axi_arvalid && !m_axi_arready && stat_stalls != '1) begin
                stat_stalls <= stat_stalls + 32'd1;
            end
        end
    end

    assign o_stat_bursts = stat_bursts;
    assign o_stat_stalls = stat_stalls;
`else
    assign o_stat_bursts = '0;
    assign o_stat_stalls = '0;
`endif

endmodule

// File: tb/tb_ch_rd_burst_gen.sv
// Directed bench for ch_rd_burst_gen: hand-computed AR bursts, outstanding limit, stalls and reset abort.
module tb_ch_rd_burst_gen;

    logic        aclk = 1'b0;
    logic        areset_n;
    logic        i_start;
    logic [63:0] i_ch_base;
    logic [31:0] i_num_bytes;
    logic        o_busy;
    logic        o_done;
    logic [63:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic        i_rlast_hs;
    logic [31:0] o_stat_bursts;
    logic [31:0] o_stat_stalls;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int dc_snap;

    logic [63:0] cap_addr[$];
    logic [7:0]  cap_len[$];

    ch_rd_burst_gen dut (
        .aclk          (aclk),
        .areset_n      (areset_n),
        .i_start       (i_start),
        .i_ch_base     (i_ch_base),
        .i_num_bytes   (i_num_bytes),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .i_rlast_hs    (i_rlast_hs),
        .o_stat_bursts (o_stat_bursts),
        .o_stat_stalls (o_stat_stalls)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (areset_n && m_axi_arvalid && m_axi_arready) begin
            cap_addr.push_back(m_axi_araddr);
            cap_len.push_back(m_axi_arlen);
        end
        if (o_done) begin
            done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [63:0] base, input logic [31:0] bytes);
        cap_addr.delete();
        cap_len.delete();
        i_ch_base   = base;
        i_num_bytes = bytes;
        i_start     = 1'b1;
        @(negedge aclk);
        i_start     = 1'b0;
    endtask

    task automatic drain(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            i_rlast_hs = 1'b1;
            @(negedge aclk);
            chk({tag, "_done_timing"}, o_done, (i == n - 1));
        end
        i_rlast_hs = 1'b0;
        @(negedge aclk);
        chk({tag, "_done_clear"}, o_done, 1'b0);
        chk({tag, "_busy_clear"}, o_busy, 1'b0);
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int n = 0;
        while (!o_done && n < max_cyc) begin
            @(negedge aclk);
            n++;
        end
        chk({tag, "_done_seen"}, o_done, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        areset_n      = 1'b0;
        i_start       = 1'b0;
        i_ch_base     = '0;
        i_num_bytes   = '0;
        m_axi_arready = 1'b1;
        i_rlast_hs    = 1'b0;
        repeat (2) @(negedge aclk);
        chk("rst_arvalid", m_axi_arvalid, 1'b0);
        chk("rst_araddr", m_axi_araddr, 64'h0);
        chk("rst_arlen", m_axi_arlen, 8'h0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_stat_bursts", o_stat_bursts, 32'h0);
        chk("rst_stat_stalls", o_stat_stalls, 32'h0);
        areset_n = 1'b1;
        @(negedge aclk);

        // 1: four full page-aligned bursts
        start(64'h1_0000_0000, 32'd16384);
        chk("t1_arvalid", m_axi_arvalid, 1'b1);
        chk("t1_araddr0", m_axi_araddr, 64'h1_0000_0000);
        chk("t1_arlen0", m_axi_arlen, 8'd63);
        chk("t1_busy", o_busy, 1'b1);
        repeat (6) @(negedge aclk);
        chk("t1_nbursts", cap_addr.size(), 4);
        chk("t1_arvalid_low", m_axi_arvalid, 1'b0);
        chk("t1_busy_drain", o_busy, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i < cap_addr.size()) begin
                chk("t1_addr", cap_addr[i], 64'h1_0000_0000 + 64'(i) * 64'h1000);
                chk("t1_len", cap_len[i], 8'd63);
            end
        end
        drain("t1", 4);

        // 2: burst split at a 4 KB boundary
        start(64'h1_0000_0F00, 32'd1024);
        repeat (4) @(negedge aclk);
        chk("t2_nbursts", cap_addr.size(), 2);
        if (cap_addr.size() == 2) begin
            chk("t2_addr0", cap_addr[0], 64'h1_0000_0F00);
            chk("t2_len0", cap_len[0], 8'd3);
            chk("t2_addr1", cap_addr[1], 64'h1_0000_1000);
            chk("t2_len1", cap_len[1], 8'd11);
        end
        drain("t2", 2);

        // 3a: partial beat rounds up, base low bits forced to zero
        start(64'h2000_0047, 32'd100);
        chk("t3_araddr", m_axi_araddr, 64'h2000_0040);
        chk("t3_arlen", m_axi_arlen, 8'd1);
        @(negedge aclk);
        chk("t3_nbursts", cap_addr.size(), 1);
        drain("t3", 1);

        // 3b: zero bytes completes immediately
        start(64'h6000_0000, 32'd0);
        chk("t3z_done", o_done, 1'b1);
        chk("t3z_busy", o_busy, 1'b0);
        chk("t3z_arvalid", m_axi_arvalid, 1'b0);
        @(negedge aclk);
        chk("t3z_done_clear", o_done, 1'b0);
        chk("t3z_arvalid2", m_axi_arvalid, 1'b0);
        chk("t3z_nbursts", cap_addr.size(), 0);

        // 4: outstanding limit with no returns
        start(64'h0, 32'd65536);
        repeat (12) @(negedge aclk);
        chk("t4_nbursts_cap", cap_addr.size(), 8);
        chk("t4_arvalid_low", m_axi_arvalid, 1'b0);
        i_ch_base   = 64'hDEAD_0000;
        i_num_bytes = 32'd64;
        i_start     = 1'b1;
        i_rlast_hs  = 1'b1;
        @(negedge aclk);
        i_start    = 1'b0;
        i_rlast_hs = 1'b0;
        repeat (3) @(negedge aclk);
        chk("t4_nbursts_release", cap_addr.size(), 9);
        chk("t4_arvalid_low2", m_axi_arvalid, 1'b0);
        i_rlast_hs = 1'b1;
        wait_done("t4", 200);
        i_rlast_hs = 1'b0;
        chk("t4_nbursts_total", cap_addr.size(), 16);
        if (cap_addr.size() == 16) begin
            chk("t4_last_addr", cap_addr[15], 64'h0000_F000);
            chk("t4_last_len", cap_len[15], 8'd63);
            chk("t4_addr8", cap_addr[8], 64'h0000_8000);
        end
        @(negedge aclk);
        chk("t4_busy_clear", o_busy, 1'b0);

        // 5: AR stall on the first burst
        m_axi_arready = 1'b0;
        start(64'h3000_0000, 32'd8192);
        for (int i = 0; i < 10; i++) begin
            chk("t5_stall_arvalid", m_axi_arvalid, 1'b1);
            chk("t5_stall_araddr", m_axi_araddr, 64'h3000_0000);
            chk("t5_stall_arlen", m_axi_arlen, 8'd63);
            @(negedge aclk);
        end
        m_axi_arready = 1'b1;
        repeat (4) @(negedge aclk);
        chk("t5_nbursts", cap_addr.size(), 2);
        if (cap_addr.size() == 2) begin
            chk("t5_addr1", cap_addr[1], 64'h3000_1000);
        end
        drain("t5", 2);
`ifdef CH_RD_STATS_EN
        chk("t5_stat_stalls", o_stat_stalls, 32'd10);
        chk("t5_stat_bursts", o_stat_bursts, 32'd2);
`else
        chk("t5_stat_stalls_off", o_stat_stalls, 32'd0);
        chk("t5_stat_bursts_off", o_stat_bursts, 32'd0);
`endif

        // 6: reset mid-issue abandons the transfer
        start(64'h4000_0000, 32'd16384);
        repeat (2) @(negedge aclk);
        chk("t6_nbursts_pre", cap_addr.size(), 2);
        areset_n = 1'b0;
        #1;
        chk("t6_rst_arvalid", m_axi_arvalid, 1'b0);
        chk("t6_rst_busy", o_busy, 1'b0);
        chk("t6_rst_araddr", m_axi_araddr, 64'h0);
        dc_snap = done_cnt;
        repeat (3) @(negedge aclk);
        areset_n = 1'b1;
        repeat (2) @(negedge aclk);
        chk("t6_no_done", done_cnt, dc_snap);
        start(64'h5000_0000, 32'd64);
        chk("t6_new_araddr", m_axi_araddr, 64'h5000_0000);
        chk("t6_new_arlen", m_axi_arlen, 8'd0);
        chk("t6_new_arvalid", m_axi_arvalid, 1'b1);
        @(negedge aclk);
        chk("t6_new_nbursts", cap_addr.size(), 1);
        drain("t6", 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
